// File: rtl/i2s_codec_if.sv
// I2S / left-justified codec master: generates bclk/lrclk from clk, serialises the
// playback pair into pbdat and deserialises recdat into left/right record samples.
module i2s_codec_if #(
  parameter int DATA_W   = 16,
  parameter int SLOT_W   = 32,
  parameter int MCLK_DIV = 4,
  parameter int MODE     = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic              bclk,
  output logic              lrclk,
  input  logic              recdat,
  output logic              pbdat,
  output logic [DATA_W-1:0] rec_left,
  output logic [DATA_W-1:0] rec_right,
  output logic              rec_valid_l,
  output logic              rec_valid_r,
  input  logic [DATA_W-1:0] pb_left,
  input  logic [DATA_W-1:0] pb_right,
  input  logic              pb_valid,
  output logic              pb_req_l,
  output logic              pb_req_r,
  output logic              underrun,
  input  logic              underrun_clr,
  output logic              running
);

  localparam int DBW = $clog2(MCLK_DIV);
  localparam int BW  = $clog2(2 * SLOT_W);

  localparam logic [DBW-1:0] D_LAST      = DBW'(MCLK_DIV - 1);
  localparam logic [DBW-1:0] D_HALF      = DBW'(MCLK_DIV / 2);
  localparam logic [DBW-1:0] D_PRE       = DBW'(MCLK_DIV / 2 - 1);
  localparam logic [BW-1:0]  B_LAST      = BW'(2 * SLOT_W - 1);
  localparam logic [BW-1:0]  B_SLOT      = BW'(SLOT_W);
  localparam logic [BW-1:0]  B_SLOT_LAST = BW'(SLOT_W - 1);
  localparam logic [BW-1:0]  P_MSB       = BW'((MODE == 0) ? 1 : 0);
  localparam logic [BW-1:0]  REL_LSB     = BW'(DATA_W - 1);
  localparam logic [BW-1:0]  REL_SPAN    = BW'(DATA_W);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [DBW-1:0]    d_q, d_d;
  logic [BW-1:0]     b_q, b_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rec_left_q, rec_left_d, rec_right_q, rec_right_d;
  logic              rec_valid_l_q, rec_valid_l_d, rec_valid_r_q, rec_valid_r_d;
  logic              bclk_q, bclk_d, lrclk_q, lrclk_d, pbdat_q, pbdat_d;
  logic              underrun_q, underrun_d;
  logic              req_l, req_r, active, d_wrap, frame_end;
  logic [BW-1:0]     rel_q, rel_d;
  logic [DATA_W-1:0] tx_shift;

  // Position of a bit counter value inside its slot, made relative to the data MSB.
  function automatic logic [BW-1:0] data_rel(input logic [BW-1:0] b);
    logic [BW-1:0] pos;
    pos = (b >= B_SLOT) ? b - B_SLOT : b;
    return pos - P_MSB;
  endfunction

  assign active    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign d_wrap    = active && (d_q == D_LAST);
  assign frame_end = d_wrap && (b_q == B_LAST);

  always_comb begin
    state_d       = state_q;
    d_d           = d_q;
    b_d           = b_q;
    tx_d          = tx_q;
    rx_d          = rx_q;
    rec_left_d    = rec_left_q;
    rec_right_d   = rec_right_q;
    rec_valid_l_d = 1'b0;
    rec_valid_r_d = 1'b0;
    underrun_d    = underrun_q;
    req_l         = 1'b0;
    req_r         = 1'b0;
    rel_q         = data_rel(b_q);
    rel_d         = '0;
    tx_shift      = '0;
    bclk_d        = 1'b0;
    lrclk_d       = 1'b0;
    pbdat_d       = 1'b0;

    if (active) begin
      d_d = d_wrap ? '0 : d_q + 1'b1;
      if (d_wrap) b_d = (b_q == B_LAST) ? '0 : b_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        d_d = '0;
        b_d = '0;
        if (enable) state_d = S_PRIME;
      end
      S_PRIME: begin
        req_l   = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        req_l = frame_end;
        if (!enable) state_d = S_DRAIN;
      end
      S_DRAIN: if (frame_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The right request keeps firing while draining so the last left/right pair stays paired.
    req_r = d_wrap && (b_q == B_SLOT_LAST);

    if (req_l) tx_d = pb_valid ? pb_left : '0;
    if (req_r) tx_d = pb_valid ? pb_right : '0;
    if ((req_l || req_r) && !pb_valid) underrun_d = 1'b1;
    if (underrun_clr) underrun_d = 1'b0;

    if (active && (d_q == D_PRE) && (rel_q < REL_SPAN)) begin
      rx_d = {rx_q[DATA_W-2:0], recdat};
      if (rel_q == REL_LSB) begin
        if (b_q < B_SLOT) begin
          rec_left_d    = rx_d;
          rec_valid_l_d = 1'b1;
        end else begin
          rec_right_d   = rx_d;
          rec_valid_r_d = 1'b1;
        end
      end
    end

    // Serial outputs are registered from next-cycle counters so they stay aligned to d/b.
    if ((state_d == S_RUN) || (state_d == S_DRAIN)) begin
      rel_d    = data_rel(b_d);
      bclk_d   = (d_d >= D_HALF);
      lrclk_d  = (b_d >= B_SLOT);
      tx_shift = tx_d >> (REL_LSB - rel_d);
      pbdat_d  = (rel_d < REL_SPAN) && tx_shift[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      d_q           <= '0;
      b_q           <= '0;
      tx_q          <= '0;
      rx_q          <= '0;
      rec_left_q    <= '0;
      rec_right_q   <= '0;
      rec_valid_l_q <= 1'b0;
      rec_valid_r_q <= 1'b0;
      bclk_q        <= 1'b0;
      lrclk_q       <= 1'b0;
      pbdat_q       <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      d_q           <= d_d;
      b_q           <= b_d;
      tx_q          <= tx_d;
      rx_q          <= rx_d;
      rec_left_q    <= rec_left_d;
      rec_right_q   <= rec_right_d;
      rec_valid_l_q <= rec_valid_l_d;
      rec_valid_r_q <= rec_valid_r_d;
      bclk_q        <= bclk_d;
      lrclk_q       <= lrclk_d;
      pbdat_q       <= pbdat_d;
      underrun_q    <= underrun_d;
    end
  end

  assign bclk        = bclk_q;
  assign lrclk       = lrclk_q;
  assign pbdat       = pbdat_q;
  assign rec_left    = rec_left_q;
  assign rec_right   = rec_right_q;
  assign rec_valid_l = rec_valid_l_q;
  assign rec_valid_r = rec_valid_r_q;
  assign pb_req_l    = req_l;
  assign pb_req_r    = req_r;
  assign underrun    = underrun_q;
  assign running     = (state_q != S_IDLE);

endmodule

// File: tb/tb_i2s_codec_if.sv
// Bench for i2s_codec_if: two configurations (I2S 16-bit, left-justified 24-bit) checked
// every cycle against a frame-time model, plus literal waveform and control-flow checks.
module tb_i2s_codec_if;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, enable, underrun_clr, pb_valid, noise_en;
  logic [31:0] pb_left_v [2];
  logic [31:0] pb_right_v[2];

  int errors = 0;
  int checks = 0;

  // Per-configuration observables: {running,bclk,lrclk,pbdat,req_l,req_r,underrun,vl,vr}
  logic [8:0]  outs_o  [2];
  logic [31:0] rec_l_o [2];
  logic [31:0] rec_r_o [2];
  logic [63:0] fb_o    [2];
  int          frames_o[2];
  int          hi_o    [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
    localparam int DW   = (gi == 0) ? 16 : 24;
    localparam int MD   = (gi == 0) ? 0 : 1;
    localparam int S    = 32;
    localparam int DIV  = 4;
    localparam int FL   = 2 * S * DIV;
    localparam int OFF  = (MD == 0) ? 1 : 0;

    logic bclk, lrclk, recdat, pbdat, rvl, rvr, rql, rqr, und, run;
    logic [DW-1:0] rl, rr;

    i2s_codec_if #(.DATA_W(DW), .SLOT_W(S), .MCLK_DIV(DIV), .MODE(MD)) u_dut (
      .clk(clk), .reset(reset), .enable(enable), .bclk(bclk), .lrclk(lrclk),
      .recdat(recdat), .pbdat(pbdat), .rec_left(rl), .rec_right(rr),
      .rec_valid_l(rvl), .rec_valid_r(rvr),
      .pb_left(pb_left_v[gi][DW-1:0]), .pb_right(pb_right_v[gi][DW-1:0]),
      .pb_valid(pb_valid), .pb_req_l(rql), .pb_req_r(rqr), .underrun(und),
      .underrun_clr(underrun_clr), .running(run)
    );

    // ADC data is the playback stream looped back, optionally corrupted by random noise.
    initial begin
      recdat = 1'b0;
      forever begin
        @(posedge clk);
        #2;
        recdat = pbdat ^ (noise_en && ($urandom_range(0, 1) == 1));
      end
    end

    // Model state: ph 0=off 1=prime 2=running; t = clk cycles since frame start.
    int ph = 0, t = 0, hi = 0, frames = 0;
    bit drain = 0;
    logic [DW-1:0] wl = '0, wr = '0, rx = '0, erl = '0, err = '0, w, tmp;
    bit evl = 0, evr = 0, eund = 0;
    logic [63:0] fb = '0, last_fb = '0;
    int last_hi = 0;

    assign outs_o[gi]   = {run, bclk, lrclk, pbdat, rql, rqr, und, rvl, rvr};
    assign rec_l_o[gi]  = 32'(rl);
    assign rec_r_o[gi]  = 32'(rr);
    assign fb_o[gi]     = last_fb;
    assign frames_o[gi] = frames;
    assign hi_o[gi]     = last_hi;

    always @(negedge clk) begin
      bit e_bclk, e_lr, e_pb, e_rql, e_rqr, e_run, was_drain;
      int d, b, p;
      logic [8:0] ev;
      e_bclk = 0; e_lr = 0; e_pb = 0; e_rql = 0; e_rqr = 0;
      d = 0; b = 0; p = 0;
      e_run = (ph != 0);
      if (ph == 1) e_rql = 1;
      if (ph == 2) begin
        d = t % DIV;
        b = t / DIV;
        p = b % S;
        e_bclk = (d >= DIV / 2);
        e_lr   = (b >= S);
        w      = (b < S) ? wl : wr;
        if (p >= OFF && p < OFF + DW) begin
          tmp  = w >> (DW - 1 - (p - OFF));
          e_pb = tmp[0];
        end
        e_rql = (t == FL - 1) && !drain;
        e_rqr = (t == S * DIV - 1);
      end
      ev = {e_run, e_bclk, e_lr, e_pb, e_rql, e_rqr, eund, evl, evr};
      checks++;
      if (outs_o[gi] !== ev) begin
        errors++;
        $display("FAIL cfg%0d outputs @%0t t=%0d: got %b required %b", gi, $time, t, outs_o[gi], ev);
      end
      checks++;
      if ({rl, rr} !== {erl, err}) begin
        errors++;
        $display("FAIL cfg%0d rec_data @%0t: got %h/%h required %h/%h", gi, $time, rl, rr, erl, err);
      end

      if (ph == 2) begin
        if (d == 0) fb = {fb[62:0], pbdat};
        if (lrclk) hi++;
        if (t == FL - 1) begin
          last_fb = fb;
          last_hi = hi;
          hi = 0;
          frames++;
        end
      end

      evl = 0;
      evr = 0;
      if (reset) begin
        ph = 0; t = 0; drain = 0; hi = 0;
        wl = '0; wr = '0; rx = '0; erl = '0; err = '0; eund = 0;
      end else begin
        if (e_rql) wl = pb_valid ? pb_left_v[gi][DW-1:0] : '0;
        if (e_rqr) wr = pb_valid ? pb_right_v[gi][DW-1:0] : '0;
        if ((e_rql || e_rqr) && !pb_valid) eund = 1;
        if (underrun_clr) eund = 0;
        if (ph == 2 && d == DIV / 2 - 1 && p >= OFF && p < OFF + DW) begin
          rx = {rx[DW-2:0], recdat};
          if (p == OFF + DW - 1) begin
            if (b < S) begin erl = rx; evl = 1; end
            else begin err = rx; evr = 1; end
          end
        end
        case (ph)
          0: if (enable) ph = 1;
          1: begin ph = 2; t = 0; end
          default: begin
            was_drain = drain;
            if (!enable) drain = 1;
            if (t == FL - 1) begin
              t = 0;
              if (was_drain) begin ph = 0; drain = 0; end
            end else begin
              t++;
            end
          end
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end else begin
      $display("check %s = %h", name, act);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout required event", name);
  endtask

  task automatic wait_req_l();
    int n = 0;
    @(negedge clk);
    while (!outs_o[0][4] && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) timeout("wait_pb_req_l");
  endtask

  task automatic wait_req_r();
    int n = 0;
    @(negedge clk);
    while (!outs_o[0][3] && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) timeout("wait_pb_req_r");
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames_o[0] < target && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) timeout("wait_frames");
  endtask

  initial begin
    int f0, nr, nq;
    reset = 1; enable = 0; underrun_clr = 0; pb_valid = 1; noise_en = 0;
    pb_left_v[0] = 32'h0000_A5C3; pb_right_v[0] = 32'h0000_8001;
    pb_left_v[1] = 32'h0012_3456; pb_right_v[1] = 32'h0080_0001;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_outputs", 64'(outs_o[0]), 64'h0);

    // Fixed samples: literal waveforms and loopback record values.
    tick();
    reset = 0;
    enable = 1;
    wait_frames(1);
    chk("pbdat_frame_i2s16", fb_o[0], {32'h52E1_8000, 32'h4000_8000});
    chk("pbdat_frame_lj24", fb_o[1], {32'h1234_5600, 32'h8000_0100});
    chk("lrclk_high_cycles", 64'(hi_o[0]), 64'd128);
    chk("rec_left_i2s16", 64'(rec_l_o[0]), 64'h0000_A5C3);
    chk("rec_right_i2s16", 64'(rec_r_o[0]), 64'h0000_8001);
    chk("rec_right_lj24", 64'(rec_r_o[1]), 64'h0080_0001);

    // Underrun on the right request only.
    wait_req_l();
    tick();
    pb_valid = 0;
    wait_req_r();
    f0 = frames_o[0];
    tick();
    pb_valid = 1;
    wait_frames(f0 + 1);
    chk("underrun_right_zero_i2s16", 64'(fb_o[0][31:0]), 64'h0);
    chk("underrun_right_zero_lj24", 64'(fb_o[1][31:0]), 64'h0);
    chk("underrun_set", 64'(outs_o[0][2]), 64'h1);
    wait_frames(f0 + 3);
    chk("underrun_sticky", 64'(outs_o[0][2]), 64'h1);
    tick();
    underrun_clr = 1;
    tick();
    underrun_clr = 0;
    @(negedge clk);
    chk("underrun_cleared", 64'(outs_o[0][2]), 64'h0);

    // Drop enable at b=10 and let the frame drain.
    wait_req_l();
    tick();
    repeat (40) tick();
    enable = 0;
    nr = 0; nq = 0;
    repeat (400) begin
      @(negedge clk);
      if (outs_o[0][8]) nr++;
      if (outs_o[0][4]) nq++;
    end
    chk("drain_running_cycles", 64'(nr), 64'd216);
    chk("drain_no_req_l", 64'(nq), 64'd0);
    chk("drain_idle_outputs", 64'(outs_o[0][8:5]), 64'h0);

    // Reset at b=40 then restart.
    tick();
    enable = 1;
    wait_req_l();
    tick();
    repeat (160) tick();
    reset = 1;
    tick();
    reset = 0;
    @(negedge clk);
    chk("midframe_reset_outputs", {23'd0, outs_o[0], rec_l_o[0]}, 64'h0);
    chk("midframe_reset_rec_right", 64'(rec_r_o[1]), 64'h0);
    tick();
    @(negedge clk);
    chk("restart_prime_req_l", 64'({outs_o[0][8], outs_o[0][4]}), 64'h3);

    // Randomized traffic with noisy record data, underruns, enable toggles and resets.
    noise_en = 1;
    for (int i = 0; i < 20000; i++) begin
      tick();
      pb_valid     = ($urandom_range(0, 15) != 0);
      pb_left_v[0] = $urandom; pb_right_v[0] = $urandom;
      pb_left_v[1] = $urandom; pb_right_v[1] = $urandom;
      underrun_clr = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 1499) == 0) enable = ~enable;
      reset = ($urandom_range(0, 7999) == 0);
    end
    tick();
    reset = 0;
    enable = 0;
    repeat (600) tick();
    @(negedge clk);
    chk("final_idle", 64'(outs_o[0][8]), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
